// File: rtl/md_sequencer_if.sv
// md_sequencer_if
//   Bundles the handshake and data signals around md_sequencer:
//     request  : req_valid/req_ready, req_funct3, req_a, req_b, flush
//     response : resp_valid/resp_ready, resp_data
//     core     : core_execute, core_div, core_a, core_b, core_ready, core_hi, core_lo
//   slave  : the sequencer's view of the bundle.
//   master : the surrounding issue logic and multiply/divide core.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             core_execute;
  logic             core_div;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_ready;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, flush, resp_ready,
           core_ready, core_hi, core_lo,
    output req_ready, resp_valid, resp_data, core_execute, core_div, core_a, core_b
  );

  modport master (
    output req_valid, req_funct3, req_a, req_b, flush, resp_ready,
           core_ready, core_hi, core_lo,
    input  req_ready, resp_valid, resp_data, core_execute, core_div, core_a, core_b
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer
//   Front-end sequencer for a shared unsigned shift-add multiply/divide core.
//   Takes an RV32M op (funct3 + rs1/rs2), turns the operands into unsigned
//   magnitudes, fires one core_execute pulse, captures the core's {hi,lo} on its
//   one-cycle core_ready pulse, then restores signs and selects the half the op
//   needs. Divide-by-zero and signed overflow are answered without the core.
// Ports
//   Clk      : clock, all state on the rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : md_sequencer_if.slave (request, response and core signals)
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           Clk,
  input  logic           Reset_n,
  md_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_FIXUP, S_RESP, S_DRAIN
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  state_t           state_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             req_ready_q, resp_valid_q, core_execute_q, core_div_q;
  logic [WIDTH-1:0] resp_data_q, core_a_q, core_b_q;

  logic             signed_a, signed_b;
  logic             sa_d, sb_d;
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic             bypass_d;
  logic [WIDTH-1:0] bypass_data_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] quo_d, rem_d, fix_data_d;

  // Operand signedness. MUL is handled as signed too: the low half of the
  // product is identical either way, and the core then sees magnitudes.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'b010:                         signed_a = 1'b1;
      default: ;
    endcase
  end

  // Setup: magnitudes and the cases the core never sees.
  always_comb begin
    sa_d          = a_q[WIDTH-1] & signed_a;
    sb_d          = b_q[WIDTH-1] & signed_b;
    // Negating MIN yields MIN, which is the correct unsigned magnitude.
    mag_a_d       = sa_d ? neg_w(a_q) : a_q;
    mag_b_d       = sb_d ? neg_w(b_q) : b_q;
    bypass_d      = 1'b0;
    bypass_data_d = '0;
    if (f3_q[2] && (b_q == '0)) begin
      bypass_d      = 1'b1;
      bypass_data_d = f3_q[1] ? a_q : ALL_ONES;
    end else if (f3_q[2] && !f3_q[0] && (a_q == MIN_VAL) && (b_q == ALL_ONES)) begin
      bypass_d      = 1'b1;
      bypass_data_d = f3_q[1] ? '0 : MIN_VAL;
    end
  end

  // Fix-up: restore signs on the captured core result and pick the half.
  always_comb begin
    prod_d = (sa_q ^ sb_q) ? neg_2w({hi_q, lo_q}) : {hi_q, lo_q};
    quo_d  = (sa_q ^ sb_q) ? neg_w(lo_q) : lo_q;
    rem_d  = sa_q ? neg_w(hi_q) : hi_q;
    if (!f3_q[2])
      fix_data_d = (f3_q[1:0] == 2'b00) ? prod_d[WIDTH-1:0] : prod_d[2*WIDTH-1:WIDTH];
    else
      fix_data_d = f3_q[1] ? rem_d : quo_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      f3_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      core_execute_q <= 1'b0;
      core_div_q     <= 1'b0;
      resp_data_q    <= '0;
      core_a_q       <= '0;
      core_b_q       <= '0;
    end else begin
      core_execute_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            f3_q        <= bus.req_funct3;
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            req_ready_q <= 1'b0;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (bus.flush) begin
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            core_a_q <= mag_a_d;
            core_b_q <= mag_b_d;
            if (bypass_d) begin
              resp_data_q  <= bypass_data_d;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              core_execute_q <= 1'b1;
              core_div_q     <= f3_q[2];
              state_q        <= S_ISSUE;
            end
          end
        end
        // The pulse is already on the wire this cycle, so a flush here must
        // still wait for the core to finish.
        S_ISSUE: state_q <= bus.flush ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (bus.core_ready) begin
            core_div_q <= 1'b0;
            if (bus.flush) begin
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              hi_q    <= bus.core_hi;
              lo_q    <= bus.core_lo;
              state_q <= S_FIXUP;
            end
          end else if (bus.flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_FIXUP: begin
          if (bus.flush) begin
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            resp_data_q  <= fix_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.flush || bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus.core_ready) begin
            core_div_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.core_execute = core_execute_q;
  assign bus.core_div     = core_div_q;
  assign bus.core_a       = core_a_q;
  assign bus.core_b       = core_b_q;

endmodule
